// File: rtl/mapper_mem_arbiter.sv
// Arbitrates the cartridge memory port between mapper-decoded CPU accesses and the
// SRAM backup engine, with a one-entry CPU pending slot, access timeout and SRAM dirty tracking.
`timescale 1ns/1ps
module mapper_mem_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 27
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_ram_cs,
    input  logic              cpu_sram_cs,
    input  logic              cpu_rnw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_wait,
    input  logic              bk_req,
    input  logic              bk_rnw,
    input  logic [ADDR_W-1:0] bk_addr,
    input  logic [7:0]        bk_wdata,
    output logic              bk_ack,
    output logic [7:0]        bk_rdata,
    output logic              mem_req,
    output logic              mem_rnw,
    output logic              mem_sram,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              sram_dirty,
    input  logic              dirty_clr,
    output logic              timeout_err
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] T_LIMIT = CW'(TIMEOUT);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CPU_ACC = 2'd1;
    localparam logic [1:0] BK_ACC  = 2'd2;

    logic [1:0]        state;
    logic              pend_valid;
    logic              pend_rnw;
    logic              pend_sram;
    logic [ADDR_W-1:0] pend_addr;
    logic [7:0]        pend_wdata;
    logic              last_cpu;
    logic [CW-1:0]     cnt;

    logic cpu_q;
    logic cpu_avail;
    logic grant_bk;
    logic grant_cpu;
    logic timed_out;
    logic done;
    logic set_dirty;

    assign cpu_q     = cpu_req & (cpu_ram_cs | cpu_sram_cs);
    assign cpu_avail = pend_valid | cpu_q;
    // Backup goes first after a CPU access so a busy CPU cannot starve the save/load engine.
    assign grant_bk  = (state == IDLE) & bk_req & (last_cpu | ~cpu_avail);
    assign grant_cpu = (state == IDLE) & cpu_avail & ~grant_bk;
    assign timed_out = (TIMEOUT != 0) && (state != IDLE) && !mem_ack && (cnt == T_LIMIT);
    assign done      = (state != IDLE) && (mem_ack || timed_out);
    assign set_dirty = (state == CPU_ACC) & mem_ack & ~mem_rnw & mem_sram;
    assign cpu_wait  = cpu_q | pend_valid | (state == CPU_ACC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pend_valid  <= 1'b0;
            pend_rnw    <= 1'b1;
            pend_sram   <= 1'b0;
            pend_addr   <= '0;
            pend_wdata  <= '0;
            last_cpu    <= 1'b0;
            cnt         <= '0;
            mem_req     <= 1'b0;
            mem_rnw     <= 1'b1;
            mem_sram    <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cpu_rdata   <= 8'hFF;
            bk_rdata    <= 8'hFF;
            bk_ack      <= 1'b0;
            sram_dirty  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            bk_ack <= 1'b0;

            if (set_dirty)
                sram_dirty <= 1'b1;
            else if (dirty_clr)
                sram_dirty <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_bk) begin
                        state     <= BK_ACC;
                        mem_req   <= 1'b1;
                        mem_rnw   <= bk_rnw;
                        mem_sram  <= 1'b1;
                        mem_addr  <= bk_addr;
                        mem_wdata <= bk_wdata;
                        cnt       <= CW'(1);
                    end else if (grant_cpu) begin
                        state   <= CPU_ACC;
                        mem_req <= 1'b1;
                        cnt     <= CW'(1);
                        if (pend_valid) begin
                            pend_valid <= 1'b0;
                            mem_rnw    <= pend_rnw;
                            mem_sram   <= pend_sram;
                            mem_addr   <= pend_addr;
                            mem_wdata  <= pend_wdata;
                        end else begin
                            mem_rnw    <= cpu_rnw;
                            mem_sram   <= cpu_sram_cs;
                            mem_addr   <= cpu_addr;
                            mem_wdata  <= cpu_wdata;
                        end
                    end
                end
                CPU_ACC, BK_ACC: begin
                    if (cnt != '1)
                        cnt <= cnt + CW'(1);
                    if (done) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        if (timed_out)
                            timeout_err <= 1'b1;
                        // A timed-out access completes as if the memory returned 8'hFF.
                        if (state == CPU_ACC) begin
                            last_cpu <= 1'b1;
                            if (mem_rnw)
                                cpu_rdata <= mem_ack ? mem_rdata : 8'hFF;
                        end else begin
                            last_cpu <= 1'b0;
                            bk_ack   <= 1'b1;
                            bk_rdata <= mem_ack ? mem_rdata : 8'hFF;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase

            if (cpu_q && !pend_valid && !grant_cpu) begin
                pend_valid <= 1'b1;
                pend_rnw   <= cpu_rnw;
                pend_sram  <= cpu_sram_cs;
                pend_addr  <= cpu_addr;
                pend_wdata <= cpu_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mapper_mem_arbiter.sv
// Directed bench for mapper_mem_arbiter: CPU reads/writes, dirty tracking, backup
// alternation, unselected requests, timeout and asynchronous reset mid-access.
`timescale 1ns/1ps
module tb_mapper_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_ram_cs;
    logic        cpu_sram_cs;
    logic        cpu_rnw;
    logic [26:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_wait;
    logic        bk_req;
    logic        bk_rnw;
    logic [26:0] bk_addr;
    logic [7:0]  bk_wdata;
    logic        bk_ack;
    logic [7:0]  bk_rdata;
    logic        mem_req;
    logic        mem_rnw;
    logic        mem_sram;
    logic [26:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        sram_dirty;
    logic        dirty_clr;
    logic        timeout_err;

    int num_compared;
    int num_mismatched;

    mapper_mem_arbiter #(.TIMEOUT(4), .ADDR_W(27)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_ram_cs(cpu_ram_cs), .cpu_sram_cs(cpu_sram_cs),
        .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
        .bk_req(bk_req), .bk_rnw(bk_rnw), .bk_addr(bk_addr), .bk_wdata(bk_wdata),
        .bk_ack(bk_ack), .bk_rdata(bk_rdata),
        .mem_req(mem_req), .mem_rnw(mem_rnw), .mem_sram(mem_sram),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .sram_dirty(sram_dirty), .dirty_clr(dirty_clr), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_compared++;
        if (observed !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic ram_cs, input logic sram_cs,
                                 input logic rnw, input logic [26:0] addr,
                                 input logic [7:0] wdata);
        cpu_req     = req;
        cpu_ram_cs  = ram_cs;
        cpu_sram_cs = sram_cs;
        cpu_rnw     = rnw;
        cpu_addr    = addr;
        cpu_wdata   = wdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        num_compared   = 0;
        num_mismatched = 0;
        reset     = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 27'h0, 8'h00);
        bk_req    = 1'b0;
        bk_rnw    = 1'b1;
        bk_addr   = 27'h0;
        bk_wdata  = 8'h00;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        dirty_clr = 1'b0;

        sample();
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_rnw", 32'(mem_rnw), 32'd1);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_cpu_rdata", 32'(cpu_rdata), 32'hFF);
        checkOutput("rst_bk_rdata", 32'(bk_rdata), 32'hFF);
        checkOutput("rst_cpu_wait", 32'(cpu_wait), 32'd0);
        checkOutput("rst_dirty", 32'(sram_dirty), 32'd0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
        step();
        reset = 1'b0;
        step();

        // CPU ROM read, memory answers in cycle 3.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 27'h0004000, 8'h00);
        sample();
        checkOutput("rd_c0_wait", 32'(cpu_wait), 32'd1);
        checkOutput("rd_c0_mem_req", 32'(mem_req), 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 27'h0, 8'h00);
        sample();
        checkOutput("rd_c1_mem_req", 32'(mem_req), 32'd1);
        checkOutput("rd_c1_mem_addr", 32'(mem_addr), 32'h0004000);
        checkOutput("rd_c1_mem_sram", 32'(mem_sram), 32'd0);
        checkOutput("rd_c1_wait", 32'(cpu_wait), 32'd1);
        step();
        sample();
        checkOutput("rd_c2_mem_req", 32'(mem_req), 32'd1);
        step();
        mem_ack = 1'b1;
        mem_rdata = 8'h3C;
        sample();
        checkOutput("rd_c3_mem_req", 32'(mem_req), 32'd1);
        checkOutput("rd_c3_wait", 32'(cpu_wait), 32'd1);
        step();
        mem_ack = 1'b0;
        sample();
        checkOutput("rd_c4_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rd_c4_wait", 32'(cpu_wait), 32'd0);
        checkOutput("rd_c4_rdata", 32'(cpu_rdata), 32'h3C);
        step();

        // SRAM write sets dirty; a clear coincident with a second write loses.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 27'h0000100, 8'h55);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 27'h0, 8'h00);
        mem_ack = 1'b1;
        sample();
        checkOutput("wr_mem_rnw", 32'(mem_rnw), 32'd0);
        checkOutput("wr_mem_sram", 32'(mem_sram), 32'd1);
        checkOutput("wr_mem_wdata", 32'(mem_wdata), 32'h55);
        checkOutput("wr_dirty_before", 32'(sram_dirty), 32'd0);
        step();
        mem_ack = 1'b0;
        sample();
        checkOutput("wr_dirty_after", 32'(sram_dirty), 32'd1);
        checkOutput("wr_done_wait", 32'(cpu_wait), 32'd0);
        step();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 27'h0000101, 8'hAA);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 27'h0, 8'h00);
        mem_ack   = 1'b1;
        dirty_clr = 1'b1;
        step();
        mem_ack   = 1'b0;
        dirty_clr = 1'b0;
        sample();
        checkOutput("set_beats_clr", 32'(sram_dirty), 32'd1);
        step();
        dirty_clr = 1'b1;
        step();
        dirty_clr = 1'b0;
        sample();
        checkOutput("clr_alone", 32'(sram_dirty), 32'd0);
        step();

        // Backup access, CPU request arrives mid-access, then alternation.
        bk_req = 1'b1;
        bk_rnw = 1'b1;
        bk_addr = 27'h0000200;
        step();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 27'h0000300, 8'h00);
        sample();
        checkOutput("bk_c1_mem_req", 32'(mem_req), 32'd1);
        checkOutput("bk_c1_mem_addr", 32'(mem_addr), 32'h0000200);
        checkOutput("bk_c1_mem_sram", 32'(mem_sram), 32'd1);
        checkOutput("bk_c1_wait", 32'(cpu_wait), 32'd1);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 27'h0, 8'h00);
        mem_ack = 1'b1;
        mem_rdata = 8'hA5;
        sample();
        checkOutput("bk_c2_pend_wait", 32'(cpu_wait), 32'd1);
        checkOutput("bk_c2_mem_addr", 32'(mem_addr), 32'h0000200);
        step();
        mem_ack = 1'b0;
        sample();
        checkOutput("bk_c3_ack", 32'(bk_ack), 32'd1);
        checkOutput("bk_c3_rdata", 32'(bk_rdata), 32'hA5);
        checkOutput("bk_c3_mem_req", 32'(mem_req), 32'd0);
        checkOutput("bk_c3_wait", 32'(cpu_wait), 32'd1);
        step();
        mem_ack = 1'b1;
        mem_rdata = 8'h11;
        sample();
        checkOutput("bk_c4_ack_pulse", 32'(bk_ack), 32'd0);
        checkOutput("bk_c4_cpu_grant", 32'(mem_addr), 32'h0000300);
        checkOutput("bk_c4_mem_sram", 32'(mem_sram), 32'd0);
        step();
        mem_ack = 1'b0;
        sample();
        checkOutput("bk_c5_cpu_rdata", 32'(cpu_rdata), 32'h11);
        checkOutput("bk_c5_wait", 32'(cpu_wait), 32'd0);
        step();
        mem_ack = 1'b1;
        mem_rdata = 8'h5A;
        sample();
        checkOutput("bk_c6_alt_req", 32'(mem_req), 32'd1);
        checkOutput("bk_c6_alt_addr", 32'(mem_addr), 32'h0000200);
        checkOutput("bk_c6_alt_sram", 32'(mem_sram), 32'd1);
        step();
        mem_ack = 1'b0;
        bk_req = 1'b0;
        sample();
        checkOutput("bk_c7_ack", 32'(bk_ack), 32'd1);
        checkOutput("bk_c7_rdata", 32'(bk_rdata), 32'h5A);
        step();
        sample();
        checkOutput("bk_c8_mem_req", 32'(mem_req), 32'd0);
        checkOutput("bk_c8_ack", 32'(bk_ack), 32'd0);
        step();

        // Request with no select active is ignored.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 27'h0000040, 8'h00);
        sample();
        checkOutput("nosel_wait_c0", 32'(cpu_wait), 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 27'h0, 8'h00);
        sample();
        checkOutput("nosel_mem_req_c1", 32'(mem_req), 32'd0);
        checkOutput("nosel_wait_c1", 32'(cpu_wait), 32'd0);
        step();

        // Timeout: no ack, TIMEOUT = 4.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 27'h00007FF, 8'h00);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 27'h0, 8'h00);
        step();
        step();
        step();
        sample();
        checkOutput("to_c4_mem_req", 32'(mem_req), 32'd1);
        checkOutput("to_c4_err", 32'(timeout_err), 32'd0);
        step();
        sample();
        checkOutput("to_c5_mem_req", 32'(mem_req), 32'd0);
        checkOutput("to_c5_rdata", 32'(cpu_rdata), 32'hFF);
        checkOutput("to_c5_err", 32'(timeout_err), 32'd1);
        checkOutput("to_c5_wait", 32'(cpu_wait), 32'd0);
        step();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 27'h0000004, 8'h00);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 27'h0, 8'h00);
        mem_ack = 1'b1;
        mem_rdata = 8'h77;
        step();
        mem_ack = 1'b0;
        sample();
        checkOutput("to_good_rdata", 32'(cpu_rdata), 32'h77);
        checkOutput("to_err_sticky", 32'(timeout_err), 32'd1);
        step();

        // Asynchronous reset in the middle of a backup access.
        bk_req = 1'b1;
        step();
        sample();
        checkOutput("rstbk_mem_req_before", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rstbk_mem_req_now", 32'(mem_req), 32'd0);
        checkOutput("rstbk_cpu_rdata", 32'(cpu_rdata), 32'hFF);
        checkOutput("rstbk_bk_rdata", 32'(bk_rdata), 32'hFF);
        checkOutput("rstbk_err", 32'(timeout_err), 32'd0);
        checkOutput("rstbk_mem_sram", 32'(mem_sram), 32'd0);
        checkOutput("rstbk_mem_rnw", 32'(mem_rnw), 32'd1);
        step();
        mem_ack = 1'b1;
        bk_req = 1'b0;
        sample();
        checkOutput("rstbk_no_ack_a", 32'(bk_ack), 32'd0);
        step();
        mem_ack = 1'b0;
        reset = 1'b0;
        sample();
        checkOutput("rstbk_no_ack_b", 32'(bk_ack), 32'd0);
        checkOutput("rstbk_idle_req", 32'(mem_req), 32'd0);
        step();
        sample();
        checkOutput("rstbk_no_ack_c", 32'(bk_ack), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
